mult_div_unit: RTL and testbench
================================

# mult_div_unit

Iterative 32-bit multiply/divide unit for the MIPS-32 execute stage, directly upstream of the register block's dual write ports. It takes two source operands, computes MULT/MULTU/DIV/DIVU over multiple cycles, and presents LO on write port 1 and HI on write port 2 with a one-cycle write pulse. The register block commits that pulse on the following negedge.

## Interface
- WIDTH, 32: operand/result width; only 32 is supported.
- REG_AW, 5: register address width.
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- operand_a  in  32  multiplicand / dividend (rs).
- operand_b  in  32  multiplier / divisor (rt).
- dest_lo  in  5  register index that receives LO.
- dest_hi  in  5  register index that receives HI.
- busy  out  1  high in CALC and DONE.
- done  out  1  one-cycle pulse in DONE.
- write_data1  out  32  LO result (product low / quotient).
- write_data2  out  32  HI result (product high / remainder).
- write_reg1  out  5  latched dest_lo.
- write_reg2  out  5  latched dest_hi.
- reg_write  out  1  write strobe for port 1, equal to done.
- enable  out  1  write strobe for port 2, equal to done.

## Operation
- States: IDLE -> CALC on start; CALC -> DONE when the iteration count reaches 31; DONE -> IDLE unconditionally.
- On accept, latch op, dest_lo, dest_hi, |a| and |b| (signed ops), and the sign flags. Clear the 64-bit accumulator and the 5-bit counter.
- Multiply: shift-add, one multiplier bit per cycle, 32 CALC cycles, 64-bit unsigned product.
- Divide: restoring shift-subtract, one quotient bit per cycle, 32 CALC cycles.
- Sign fix on the CALC -> DONE transition:
  - Product is negated if sign_a XOR sign_b.
  - Quotient is negated if sign_a XOR sign_b.
  - Remainder takes the sign of the dividend.
- Divide by zero: no trap, same latency. Forced result is LO = 0xFFFFFFFF, HI = operand_a.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. This falls out of the unsigned path plus sign fix.
- start while busy: ignored. Operand changes after acceptance have no effect.
- Outputs write_data1/2 and write_reg1/2 hold their last values in IDLE.

## Timing
- Reset values: busy, done, reg_write, enable are 0; write_data1/2 are 0; write_reg1/2 are 0; state is IDLE; counter is 0.
- Accept at posedge N. busy is high from N to N+33. done, reg_write and enable are high for exactly cycle N+33 (between posedges N+33 and N+34).
- Latency from start to done is 33 cycles. Back-to-back throughput is one op per 34 cycles; the next start is accepted at posedge N+34 at the earliest.
- The write pulse lands on the negedge inside the DONE cycle, so data is stable a half-cycle before the register block samples it.
- Reset mid-operation clears to IDLE immediately (asynchronous). No write pulse is produced for the aborted op.

## Configuration
- MDU_DIV_EN defined: full divide datapath as described.
- MDU_DIV_EN undefined: divider logic is removed. DIV/DIVU is accepted and goes straight IDLE -> DONE in one cycle, with done high, reg_write = enable = 0, and write_data unchanged. Multiply is unaffected.

## Structure
- mdu_pkg holds:
  - op encodings (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU)
  - the state enum (IDLE, CALC, DONE)
  - ITER_LAST = 31
  - the divide-by-zero LO constant
- Sub-module mdu_datapath holds the 64-bit accumulator, the shift-add / shift-subtract step and the sign fix. The top level keeps the FSM, counter, latches and write-port drive.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> LO 0x00000001, HI 0xFFFFFFFE. done exactly 33 cycles after start, one cycle wide.
- MULT 0xFFFFFFFD (-3) × 7 -> LO 0xFFFFFFEB, HI 0xFFFFFFFF. write_reg1 = dest_lo and write_reg2 = dest_hi as latched.
- DIV 0xFFFFFFF9 (-7) / 2 -> LO 0xFFFFFFFD, HI 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> LO 0x80000000, HI 0.
- DIVU 100 / 0 -> LO 0xFFFFFFFF, HI 0x00000064, same 33-cycle latency.
- start pulsed at cycles 5 and 20 of an op, with operands changed -> ignored; result matches the original operands.
- reset asserted at CALC cycle 10 -> busy falls immediately, no reg_write/enable pulse. A following MULTU 6 × 7 -> LO 42, HI 0.

Source files
------------

// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the iterative multiply/divide unit:
//   - op encodings driven on mult_div_unit.op
//   - FSM state enum
//   - ITER_LAST: final iteration index of the 32-step CALC loop
//   - DIV0_LO: LO value forced for a divide by zero
//   - magnitude(): two's-complement absolute value helper
// -----------------------------------------------------------------------------
package mdu_pkg;

   localparam logic [1:0] MDU_MULT  = 2'b00;
   localparam logic [1:0] MDU_MULTU = 2'b01;
   localparam logic [1:0] MDU_DIV   = 2'b10;
   localparam logic [1:0] MDU_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } mdu_state_t;

   localparam logic [4:0]  ITER_LAST = 5'd31;
   localparam logic [31:0] DIV0_LO   = 32'hFFFF_FFFF;

   // 0x80000000 maps onto itself, which is also its correct unsigned magnitude.
   function automatic logic [31:0] magnitude(input logic signed [31:0] v,
                                             input logic is_signed);
      logic [31:0] u;
      u = v;
      if (is_signed && (v < 0))
         return ~u + 32'd1;
      return u;
   endfunction

endpackage

// File: rtl/mdu_datapath.sv
// -----------------------------------------------------------------------------
// mdu_datapath
// 64-bit accumulator with one shift-add (multiply) or restoring shift-subtract
// (divide) step per cycle, plus the sign fix applied to the final step result.
// Divider hardware exists only when MDU_DIV_EN is defined.
//
// Ports:
//   clk            clock
//   clear          zero the accumulator (operation accept)
//   load           load the multiplier (mult) or dividend (div) into acc[31:0]
//   step           perform one iteration
//   is_div         latched: operation is a divide
//   sign_a/sign_b  latched operand signs (0 for unsigned ops)
//   mag_a/mag_b    latched operand magnitudes
//   fix_lo/fix_hi  sign-corrected LO/HI of the result of the current step
// -----------------------------------------------------------------------------
module mdu_datapath
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             load,
   input  logic             step,
   input  logic             is_div,
   input  logic             sign_a,
   input  logic             sign_b,
   input  logic [WIDTH-1:0] mag_a,
   input  logic [WIDTH-1:0] mag_b,
   output logic [WIDTH-1:0] fix_lo,
   output logic [WIDTH-1:0] fix_hi
);

   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] acc_next;
   logic [2*WIDTH-1:0] acc_mul;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH:0]     sum;
`ifdef MDU_DIV_EN
   logic [WIDTH:0]     part_rem;
   logic [WIDTH+1:0]   diff;
   logic [2*WIDTH-1:0] acc_div;
`endif

   always_ff @(posedge clk) begin
      if (clear)
         acc_q <= '0;
      else if (load)
         acc_q <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
      else if (step)
         acc_q <= acc_next;
   end

   always_comb begin
      // Shift-add: add multiplicand into the high half when the multiplier
      // LSB is set, then shift the whole accumulator right by one.
      sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mag_a};
      acc_mul = acc_q[0] ? {sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
      acc_next = acc_mul;
      prod     = (sign_a ^ sign_b) ? -acc_mul : acc_mul;
      fix_lo   = prod[WIDTH-1:0];
      fix_hi   = prod[2*WIDTH-1:WIDTH];
`ifdef MDU_DIV_EN
      // Restoring divide: partial remainder (one bit wider after the shift)
      // is compared against the divisor; quotient bits enter at the bottom.
      part_rem = acc_q[2*WIDTH-1:WIDTH-1];
      diff     = {1'b0, part_rem} - {2'b00, mag_b};
      acc_div  = diff[WIDTH+1] ? {part_rem[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                               : {diff[WIDTH-1:0],     acc_q[WIDTH-2:0], 1'b1};
      if (is_div) begin
         acc_next = acc_div;
         fix_lo   = (sign_a ^ sign_b) ? -acc_div[WIDTH-1:0] : acc_div[WIDTH-1:0];
         fix_hi   = sign_a ? -acc_div[2*WIDTH-1:WIDTH] : acc_div[2*WIDTH-1:WIDTH];
      end
`endif
   end

endmodule

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
// Iterative MULT/MULTU/DIV/DIVU unit. LO goes out on write port 1, HI on write
// port 2, with a one-cycle write strobe while in DONE. Accept-to-done is 33
// cycles: one accumulator load cycle followed by 32 iterations.
//
// Build option: MDU_DIV_EN. When undefined the divider is removed and
// DIV/DIVU pass IDLE -> DONE in one cycle with no write strobe.
//
// Ports:
//   clk, reset (async, active-high)
//   start, op, operand_a, operand_b, dest_lo, dest_hi   request
//   busy, done                                          status
//   write_data1/write_reg1/reg_write                    port 1 (LO)
//   write_data2/write_reg2/enable                       port 2 (HI)
// -----------------------------------------------------------------------------
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [WIDTH-1:0]  operand_a,
   input  logic [WIDTH-1:0]  operand_b,
   input  logic [REG_AW-1:0] dest_lo,
   input  logic [REG_AW-1:0] dest_hi,
   output logic              busy,
   output logic              done,
   output logic [WIDTH-1:0]  write_data1,
   output logic [WIDTH-1:0]  write_data2,
   output logic [REG_AW-1:0] write_reg1,
   output logic [REG_AW-1:0] write_reg2,
   output logic              reg_write,
   output logic              enable
);

`ifdef MDU_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   mdu_state_t        state_q, state_d;
   logic [4:0]        count_q;
   logic              primed_q;
   logic              wr_q;
   logic              accept, finish;
   logic              is_div_in, is_signed_in, skip_div;
   logic              is_div_q, sign_a_q, sign_b_q;
   logic [WIDTH-1:0]  mag_a_q, mag_b_q;
   logic [REG_AW-1:0] dest_lo_q, dest_hi_q;
   logic [WIDTH-1:0]  fix_lo, fix_hi;
`ifdef MDU_DIV_EN
   logic              div0_q;
   logic [WIDTH-1:0]  a_raw_q;
`endif

   always_comb begin
      is_div_in    = 1'b0;
      is_signed_in = 1'b0;
      case (op)
         MDU_MULT:  is_signed_in = 1'b1;
         MDU_MULTU: is_signed_in = 1'b0;
         MDU_DIV:   begin is_div_in = 1'b1; is_signed_in = 1'b1; end
         MDU_DIVU:  is_div_in = 1'b1;
         default:   ;
      endcase
   end

   assign skip_div = is_div_in & ~DIV_EN;

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      finish  = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            accept  = 1'b1;
            state_d = skip_div ? DONE : CALC;
         end
         // The first CALC cycle loads the accumulator; iterations follow.
         CALC: if (primed_q && (count_q == ITER_LAST)) begin
            finish  = 1'b1;
            state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Operand latches: only meaningful after accept, so no reset needed.
   always_ff @(posedge clk) begin
      if (accept) begin
         is_div_q  <= is_div_in;
         sign_a_q  <= is_signed_in & operand_a[WIDTH-1];
         sign_b_q  <= is_signed_in & operand_b[WIDTH-1];
         mag_a_q   <= magnitude(operand_a, is_signed_in);
         mag_b_q   <= magnitude(operand_b, is_signed_in);
         dest_lo_q <= dest_lo;
         dest_hi_q <= dest_hi;
`ifdef MDU_DIV_EN
         div0_q    <= is_div_in && (operand_b == '0);
         a_raw_q   <= operand_a;
`endif
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         count_q     <= '0;
         primed_q    <= 1'b0;
         wr_q        <= 1'b0;
         write_data1 <= '0;
         write_data2 <= '0;
         write_reg1  <= '0;
         write_reg2  <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            count_q  <= '0;
            primed_q <= 1'b0;
            wr_q     <= ~skip_div;
         end else if (state_q == CALC) begin
            if (!primed_q)
               primed_q <= 1'b1;
            else
               count_q <= count_q + 5'd1;
         end
         if (finish) begin
`ifdef MDU_DIV_EN
            if (div0_q) begin
               write_data1 <= DIV0_LO;
               write_data2 <= a_raw_q;
            end else begin
               write_data1 <= fix_lo;
               write_data2 <= fix_hi;
            end
`else
            write_data1 <= fix_lo;
            write_data2 <= fix_hi;
`endif
            write_reg1 <= dest_lo_q;
            write_reg2 <= dest_hi_q;
         end
      end
   end

   mdu_datapath #(.WIDTH(WIDTH)) u_datapath (
      .clk    (clk),
      .clear  (accept),
      .load   ((state_q == CALC) && !primed_q),
      .step   ((state_q == CALC) && primed_q),
      .is_div (is_div_q),
      .sign_a (sign_a_q),
      .sign_b (sign_b_q),
      .mag_a  (mag_a_q),
      .mag_b  (mag_b_q),
      .fix_lo (fix_lo),
      .fix_hi (fix_hi)
   );

   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign reg_write = done & wr_q;
   assign enable    = done & wr_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit
// Directed checks of mult_div_unit: reset state, multiply/divide results,
// accept-to-done latency, done width, latched destinations, start-while-busy
// and asynchronous reset abort. Divide expectations follow MDU_DIV_EN.
// -----------------------------------------------------------------------------
module tb_mult_div_unit;
   import mdu_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] operand_a, operand_b;
   logic [4:0]  dest_lo, dest_hi;
   logic        busy, done, reg_write, enable;
   logic [31:0] write_data1, write_data2;
   logic [4:0]  write_reg1, write_reg2;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mult_div_unit dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .op          (op),
      .operand_a   (operand_a),
      .operand_b   (operand_b),
      .dest_lo     (dest_lo),
      .dest_hi     (dest_hi),
      .busy        (busy),
      .done        (done),
      .write_data1 (write_data1),
      .write_data2 (write_data2),
      .write_reg1  (write_reg1),
      .write_reg2  (write_reg2),
      .reg_write   (reg_write),
      .enable      (enable)
   );

   task automatic check_val(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Issue one op; lat = cycles from accept edge to the cycle with done high
   // (-1 if done never shows). Returns at the negedge inside the done cycle.
   task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] dl,
                         input logic [4:0] dh, input bit inject,
                         output int lat);
      @(negedge clk);
      op = o; operand_a = a; operand_b = b; dest_lo = dl; dest_hi = dh;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      lat = -1;
      for (int k = 1; k <= 100; k++) begin
         if (k > 1) @(negedge clk);
         if (inject && (k == 5 || k == 20)) begin
            start = 1'b1; op = MDU_MULT;
            operand_a = $urandom; operand_b = 32'hFFFF_FFFF;
            dest_lo = 5'd31; dest_hi = 5'd30;
         end else begin
            start = 1'b0;
         end
         if (done) begin
            lat = k - 1;
            break;
         end
      end
      start = 1'b0;
   endtask

   task automatic do_op(input string tag, input logic [1:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] dl, input logic [4:0] dh,
                        input bit inject, input int exp_lat,
                        input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                        input logic exp_we, input logic [4:0] exp_r1,
                        input logic [4:0] exp_r2);
      int lat;
      run_op(o, a, b, dl, dh, inject, lat);
      check_val({tag, "_lat"},  lat, exp_lat);
      check_val({tag, "_lo"},   write_data1, exp_lo);
      check_val({tag, "_hi"},   write_data2, exp_hi);
      check_val({tag, "_rw"},   reg_write, exp_we);
      check_val({tag, "_en"},   enable, exp_we);
      check_val({tag, "_wr1"},  write_reg1, exp_r1);
      check_val({tag, "_wr2"},  write_reg2, exp_r2);
      @(negedge clk);
      check_val({tag, "_width"}, done, 1'b0);
      check_val({tag, "_idle"},  busy, 1'b0);
   endtask

   initial begin
      int pulses;
      reset = 1'b1; start = 1'b0; op = 2'b00;
      operand_a = '0; operand_b = '0; dest_lo = '0; dest_hi = '0;
      repeat (3) @(negedge clk);
      check_val("rst_busy", busy, 1'b0);
      check_val("rst_done", done, 1'b0);
      check_val("rst_rw",   reg_write, 1'b0);
      check_val("rst_en",   enable, 1'b0);
      check_val("rst_wd1",  write_data1, 32'h0);
      check_val("rst_wd2",  write_data2, 32'h0);
      check_val("rst_wr1",  write_reg1, 5'd0);
      check_val("rst_wr2",  write_reg2, 5'd0);
      reset = 1'b0;

      do_op("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 5'd4, 1'b0,
            33, 32'h0000_0001, 32'hFFFF_FFFE, 1'b1, 5'd3, 5'd4);
      do_op("mult_neg", MDU_MULT, 32'hFFFF_FFFD, 32'd7, 5'd5, 5'd6, 1'b0,
            33, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b1, 5'd5, 5'd6);
`ifdef MDU_DIV_EN
      do_op("div_neg", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 5'd7, 5'd8, 1'b0,
            33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b1, 5'd7, 5'd8);
      do_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 5'd14, 1'b0,
            33, 32'h8000_0000, 32'h0000_0000, 1'b1, 5'd13, 5'd14);
      do_op("divu_zero", MDU_DIVU, 32'd100, 32'd0, 5'd15, 5'd16, 1'b0,
            33, DIV0_LO, 32'h0000_0064, 1'b1, 5'd15, 5'd16);
`else
      do_op("div_neg", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 5'd7, 5'd8, 1'b0,
            0, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0, 5'd5, 5'd6);
      do_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 5'd14, 1'b0,
            0, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0, 5'd5, 5'd6);
      do_op("divu_zero", MDU_DIVU, 32'd100, 32'd0, 5'd15, 5'd16, 1'b0,
            0, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0, 5'd5, 5'd6);
`endif
      do_op("ignore_start", MDU_MULTU, 32'h1234_5678, 32'h0000_0100, 5'd9, 5'd10, 1'b1,
            33, 32'h3456_7800, 32'h0000_0012, 1'b1, 5'd9, 5'd10);

      // Abort an op with reset part-way through CALC.
      @(negedge clk);
      op = MDU_MULTU; operand_a = 32'd5; operand_b = 32'd5;
      dest_lo = 5'd20; dest_hi = 5'd21; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      check_val("abort_busy_before", busy, 1'b1);
      reset = 1'b1;
      #1;
      check_val("abort_busy", busy, 1'b0);
      check_val("abort_done", done, 1'b0);
      check_val("abort_wd1",  write_data1, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      pulses = 0;
      repeat (40) begin
         @(negedge clk);
         if (reg_write || enable || done) pulses++;
      end
      check_val("abort_no_pulse", pulses, 0);

      do_op("multu_after", MDU_MULTU, 32'd6, 32'd7, 5'd11, 5'd12, 1'b0,
            33, 32'd42, 32'd0, 1'b1, 5'd11, 5'd12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation time limit reached");
   end

endmodule
